// File: rtl/vr_tooth_capture.sv
// vr_tooth_capture
//   Conditions the raw VR crank comparator signal for the downstream angle
//   generator. The processing chain is:
//     1. 2-FF synchroniser.
//     2. Stability filter (FILT_LEN consecutive differing samples).
//     3. Edge select.
//     4. Minimum-period blanking against the last accepted tooth period.
//
// Parameters
//   FILT_LEN     consecutive differing samples before vr_out flips (2..15)
//   PCNT_W       width of the period counter and tooth_period
//   BLANK_SHIFT  blanking window = last accepted period >> BLANK_SHIFT
//
// Ports
//   clk           system clock, posedge
//   rst           synchronous reset, active-high
//   enable        1 = capture running, 0 = capture held idle
//   edge_sel      0 = rising vr_out is a tooth, 1 = falling vr_out is a tooth
//   vr_in         raw asynchronous comparator input
//   vr_out        filtered, synchronised level
//   tooth_stb     1-cycle strobe per accepted tooth with a valid period
//   tooth_period  clk cycles between the last two accepted teeth
//   stall         period counter saturated (no tooth for 2^PCNT_W-1 cycles)
//   reject_cnt    count of blanked edges, saturating at 255
module vr_tooth_capture #(
    parameter int FILT_LEN    = 4,
    parameter int PCNT_W      = 24,
    parameter int BLANK_SHIFT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              enable,
    input  logic              edge_sel,
    input  logic              vr_in,
    output logic              vr_out,
    output logic              tooth_stb,
    output logic [PCNT_W-1:0] tooth_period,
    output logic              stall,
    output logic [7:0]        reject_cnt
);

    localparam logic [3:0]        RUN_LAST = 4'(FILT_LEN - 1);
    localparam logic [PCNT_W-1:0] CNT_ONE  = PCNT_W'(1);
    localparam logic [PCNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FIRST = 2'd1,
        RUN   = 2'd2
    } state_t;

    function automatic logic [PCNT_W-1:0] cnt_sat_inc(input logic [PCNT_W-1:0] v);
        return (v == CNT_MAX) ? v : v + CNT_ONE;
    endfunction

    function automatic logic [7:0] rej_sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

    logic              sync_p0;
    logic              sync_p1;
    logic [3:0]        run_cnt;
    logic              vr_prev;
    logic              cand_p3;

    state_t            state_q;
    state_t            state_d;
    logic [PCNT_W-1:0] cnt;
    logic [PCNT_W-1:0] cnt_d;
    logic [PCNT_W-1:0] last_period;
    logic [PCNT_W-1:0] last_period_d;
    logic [PCNT_W-1:0] tooth_period_d;
    logic              tooth_stb_d;
    logic [7:0]        reject_cnt_d;
    logic [PCNT_W-1:0] blank;

    // Synchroniser, stability filter and edge-candidate register.
    // The filter runs independently of enable so vr_out is always valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync_p0 <= 1'b0;
            sync_p1 <= 1'b0;
            run_cnt <= '0;
            vr_out  <= 1'b0;
            vr_prev <= 1'b0;
            cand_p3 <= 1'b0;
        end else begin
            sync_p0 <= vr_in;
            sync_p1 <= sync_p0;
            if (sync_p1 != vr_out) begin
                if (run_cnt == RUN_LAST) begin
                    vr_out  <= ~vr_out;
                    run_cnt <= '0;
                end else begin
                    run_cnt <= run_cnt + 4'd1;
                end
            end else begin
                run_cnt <= '0;
            end
            vr_prev <= vr_out;
            cand_p3 <= edge_sel ? (vr_prev & ~vr_out) : (~vr_prev & vr_out);
        end
    end

    // A saturated counter means the previous tooth is too old to give a
    // meaningful period; the next candidate resynchronises instead.
    assign stall = (cnt == CNT_MAX);
    assign blank = last_period >> BLANK_SHIFT;

    always_comb begin
        state_d        = state_q;
        cnt_d          = cnt;
        last_period_d  = last_period;
        tooth_period_d = tooth_period;
        tooth_stb_d    = 1'b0;
        reject_cnt_d   = reject_cnt;

        if (!enable) begin
            state_d       = IDLE;
            cnt_d         = '0;
            last_period_d = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d   = '0;
                    state_d = FIRST;
                end
                FIRST: begin
                    if (cand_p3) begin
                        cnt_d         = CNT_ONE;
                        last_period_d = '0;
                        state_d       = RUN;
                    end
                end
                RUN: begin
                    if (cand_p3) begin
                        if (stall) begin
                            cnt_d         = CNT_ONE;
                            last_period_d = '0;
                        end else if (cnt >= blank) begin
                            tooth_stb_d    = 1'b1;
                            tooth_period_d = cnt;
                            last_period_d  = cnt;
                            cnt_d          = CNT_ONE;
                        end else begin
                            cnt_d        = cnt_sat_inc(cnt);
                            reject_cnt_d = rej_sat_inc(reject_cnt);
                        end
                    end else begin
                        cnt_d = cnt_sat_inc(cnt);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // Capture FSM and period registers; the strobe is one cycle after the candidate.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt          <= '0;
            last_period  <= '0;
            tooth_period <= '0;
            tooth_stb    <= 1'b0;
            reject_cnt   <= '0;
        end else begin
            state_q      <= state_d;
            cnt          <= cnt_d;
            last_period  <= last_period_d;
            tooth_period <= tooth_period_d;
            tooth_stb    <= tooth_stb_d;
            reject_cnt   <= reject_cnt_d;
        end
    end

endmodule

// File: tb/tb_vr_tooth_capture.sv
// tb_vr_tooth_capture
//   Bench for vr_tooth_capture with FILT_LEN=4, PCNT_W=8, BLANK_SHIFT=2.
//   Expected strobes (cycle and period) are queued when an edge is driven
//   and compared when the DUT raises tooth_stb.
module tb_vr_tooth_capture;

    localparam int FILT_LEN    = 4;
    localparam int PCNT_W      = 8;
    localparam int BLANK_SHIFT = 2;
    localparam int STB_LAT     = 2 + FILT_LEN + 2;

    logic              clk;
    logic              rst;
    logic              enable;
    logic              edge_sel;
    logic              vr_in;
    logic              vr_out;
    logic              tooth_stb;
    logic [PCNT_W-1:0] tooth_period;
    logic              stall;
    logic [7:0]        reject_cnt;

    typedef struct {
        int cyc;
        int period;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   cyc          = 0;
    int   last_stb_cyc = 0;
    int   n_checks     = 0;
    int   n_fail       = 0;
    logic seen_high;

    vr_tooth_capture #(
        .FILT_LEN   (FILT_LEN),
        .PCNT_W     (PCNT_W),
        .BLANK_SHIFT(BLANK_SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .enable      (enable),
        .edge_sel    (edge_sel),
        .vr_in       (vr_in),
        .vr_out      (vr_out),
        .tooth_stb   (tooth_stb),
        .tooth_period(tooth_period),
        .stall       (stall),
        .reject_cnt  (reject_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_exp(input int period);
        exp_t e;
        e.cyc    = cyc + STB_LAT;
        e.period = period;
        sb_q.push_back(e);
    endtask

    // One high/low pulse; when a strobe is expected it is queued at the
    // edge that edge_sel selects.
    task automatic pulse(input int hi, input int lo, input bit exp_stb, input int period);
        if (exp_stb && !edge_sel) push_exp(period);
        vr_in = 1'b1;
        tick(hi);
        if (exp_stb && edge_sel) push_exp(period);
        vr_in = 1'b0;
        tick(lo);
    endtask

    always @(negedge clk) begin
        if (tooth_stb) begin
            last_stb_cyc = cyc;
            if (sb_q.size() == 0) begin
                check("stb_unexpected", tooth_stb, 0);
            end else begin
                mon_e = sb_q.pop_front();
                check("stb_cycle", cyc, mon_e.cyc);
                check("stb_period", tooth_period, mon_e.period);
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        edge_sel = 1'b0;
        vr_in    = 1'b0;
        tick(3);
        check("rst_vr_out", vr_out, 0);
        check("rst_stb", tooth_stb, 0);
        check("rst_period", tooth_period, 0);
        check("rst_stall", stall, 0);
        check("rst_reject", reject_cnt, 0);
        rst = 1'b0;
        tick(2);

        // Filter: a 3-clock glitch is swallowed, 4 clocks pass after 6 clocks.
        vr_in = 1'b1;
        tick(3);
        vr_in = 1'b0;
        seen_high = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tick();
            seen_high |= vr_out;
        end
        check("t1_glitch", seen_high, 0);
        vr_in = 1'b1;
        tick(4);
        vr_in = 1'b0;
        tick();
        check("t1_lat_early", vr_out, 0);
        tick();
        check("t1_lat", vr_out, 1);
        tick(12);
        check("t1_back_low", vr_out, 0);

        // Steady rising teeth every 100 clocks; the first one is silent.
        enable = 1'b1;
        tick(3);
        for (int i = 0; i < 5; i++) pulse(50, 50, i > 0, 100);
        check("t2_period", tooth_period, 100);
        check("t2_drain", sb_q.size(), 0);

        // Extra edge 20 clocks after a tooth falls inside the 25-clock blank.
        push_exp(100);
        vr_in = 1'b1;
        tick(10);
        vr_in = 1'b0;
        tick(10);
        vr_in = 1'b1;
        tick(10);
        vr_in = 1'b0;
        tick(70);
        check("t3_reject", reject_cnt, 1);
        pulse(50, 50, 1'b1, 100);
        check("t3_period", tooth_period, 100);
        check("t3_reject_hold", reject_cnt, 1);
        check("t3_drain", sb_q.size(), 0);

        // Stall at cnt=255, silent resync, then 50-clock teeth.
        while (cyc < last_stb_cyc + 253) tick();
        check("t4_stall_pre", stall, 0);
        tick();
        check("t4_stall", stall, 1);
        tick(20);
        check("t4_stall_held", stall, 1);
        pulse(25, 25, 1'b0, 0);
        check("t4_stall_clr", stall, 0);
        check("t4_period_hold", tooth_period, 100);
        pulse(25, 25, 1'b1, 50);
        pulse(25, 25, 1'b1, 50);
        check("t4_period", tooth_period, 50);
        check("t4_drain", sb_q.size(), 0);

        // Reset in the middle of a running capture with vr_in toggling.
        push_exp(50);
        vr_in = 1'b1;
        tick(10);
        vr_in = 1'b0;
        tick(10);
        vr_in = 1'b1;
        tick(3);
        rst = 1'b1;
        tick();
        check("t5_vr_out", vr_out, 0);
        check("t5_stb", tooth_stb, 0);
        check("t5_period", tooth_period, 0);
        check("t5_stall", stall, 0);
        check("t5_reject", reject_cnt, 0);
        vr_in = 1'b0;
        tick(2);
        vr_in = 1'b1;
        tick(2);
        vr_in = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(12);
        pulse(40, 40, 1'b0, 0);
        check("t5_silent", tooth_period, 0);
        pulse(40, 40, 1'b1, 80);
        pulse(40, 40, 1'b1, 80);
        check("t5_reject_end", reject_cnt, 0);
        check("t5_drain", sb_q.size(), 0);

        // Falling-edge teeth, 30% duty, period 80.
        enable   = 1'b0;
        edge_sel = 1'b1;
        tick();
        enable = 1'b1;
        tick(2);
        pulse(24, 56, 1'b0, 0);
        for (int i = 0; i < 3; i++) pulse(24, 56, 1'b1, 80);
        check("t6_period", tooth_period, 80);
        enable = 1'b0;
        tick();
        enable = 1'b1;
        tick();
        check("t6_hold_drop", tooth_period, 80);
        pulse(24, 56, 1'b0, 0);
        check("t6_hold_silent", tooth_period, 80);
        check("t6_stall", stall, 0);
        pulse(24, 56, 1'b1, 80);
        tick(12);
        check("t6_period_end", tooth_period, 80);
        check("final_drain", sb_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
